// File: rtl/x_run_fsm.sv
// Run-of-ones detector: flags a hit once x_in has been 1 for `target` consecutive
// enabled cycles, with overlap control, a registered hit flag and a saturating hit counter.
module x_run_fsm #(
    parameter int CNT_W = 4,
    parameter int HIT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             x_in,
    input  logic [CNT_W-1:0] target,
    input  logic             overlap,
    input  logic             clr,
    output logic             y_out,
    output logic             y_reg,
    output logic [HIT_W-1:0] hit_count,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        MATCH = 2'd2
    } state_e;

    // Largest run value ever stored; keeps run_q from wrapping when target is 0.
    localparam logic [CNT_W-1:0] RUN_MAX = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [HIT_W-1:0] HIT_MAX = {HIT_W{1'b1}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic [HIT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] target_m1;
    logic             hit;

    assign target_m1 = target - {{(CNT_W-1){1'b0}}, 1'b1};
    // Gated by reset so the Mealy output drops the instant reset is asserted.
    assign hit = reset & en & x_in & (target != '0) & (run_q >= target_m1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            run_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        cnt_d   = cnt_q;
        if (en) begin
            if (!x_in) begin
                state_d = IDLE;
                run_d   = '0;
            end else if (hit) begin
                state_d = MATCH;
                run_d   = overlap ? target_m1 : '0;
            end else begin
                state_d = ACC;
                run_d   = (run_q == RUN_MAX) ? run_q : run_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
        // clr wins over a coincident hit and works regardless of en.
        if (clr) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != HIT_MAX)) begin
            cnt_d = cnt_q + {{(HIT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        y_out     = hit;
        y_reg     = (state_q == MATCH);
        hit_count = cnt_q;
        dbg_state = state_q;
    end

endmodule
